// File: rtl/iir_pkg.sv
// Shared types and helpers for the IIR filter back-end (decimator and its output buffer).
package iir_pkg;

  localparam int unsigned IIR_DATA_W = 8;

  typedef logic signed [IIR_DATA_W-1:0] sample_t;

  typedef enum logic {
    ACCUM = 1'b0,
    LAST  = 1'b1
  } dec_state_e;

  // Ceiling log2, usable in constant expressions
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/iir_decimator_if.sv
// Sample-in / decimated-out bus of the IIR decimator; slave is the decimator side.
interface iir_decimator_if;
  import iir_pkg::*;

  logic    sleep;
  sample_t in_data;
  logic    in_valid;
  sample_t out_data;
  logic    out_valid;
  logic    out_ready;
  logic    overrun;

  modport master (
    output sleep, in_data, in_valid, out_ready,
    input  out_data, out_valid, overrun
  );

  modport slave (
    input  sleep, in_data, in_valid, out_ready,
    output out_data, out_valid, overrun
  );

endinterface

// File: rtl/iir_out_fifo.sv
// Two-entry in-order output buffer; the head entry is held in a register and drives dout.
module iir_out_fifo
  import iir_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  sample_t din,
  output sample_t dout,
  output logic    full,
  output logic    empty
);

  localparam int unsigned CNT_W = clog2(DEPTH + 1);

  logic [CNT_W-1:0] count_q;
  sample_t          head_q;
  sample_t          tail_q;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = head_q;

  // A pop frees a slot in the same edge, so a push while full is still taken
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else if (pop) begin
      if (push && count_q == CNT_W'(1)) head_q <= din;
      else                              head_q <= tail_q;
      if (push)  tail_q  <= din;
      if (!push) count_q <= count_q - CNT_W'(1);
    end else if (push && !full) begin
      if (empty) head_q <= din;
      else       tail_q <= din;
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/iir_decimator.sv
// Block-averaging decimator behind the IIR filter; one output per DECIM accepted samples.
// Build option: define IIR_DECIM_ROUND_EN for round-half-up averaging instead of floor.
module iir_decimator
  import iir_pkg::*;
#(
  parameter int unsigned DATA_W = IIR_DATA_W,
  parameter int unsigned DECIM  = 4,
  parameter int unsigned FIFO_D = 2
) (
  input  logic           clk,
  input  logic           rst,
  iir_decimator_if.slave bus
);

  localparam int unsigned LOG2_DECIM = clog2(DECIM);
  localparam int unsigned ACC_W      = DATA_W + LOG2_DECIM;

  dec_state_e                  state_q, state_d;
  logic signed [ACC_W-1:0]     acc_q;
  logic signed [ACC_W-1:0]     sum_c;
  logic signed [ACC_W-1:0]     rnd_c;
  logic [LOG2_DECIM-1:0]       cnt_q;
  logic signed [DATA_W-1:0]    result_c;
  logic                        accept_c;
  logic                        push_c;
  logic                        pop_c;
  logic                        full;
  logic                        empty;
  logic                        overrun_q;

  assign accept_c = bus.in_valid & ~bus.sleep;
  assign pop_c    = bus.out_ready & ~empty;
  assign sum_c    = acc_q + {{LOG2_DECIM{bus.in_data[DATA_W-1]}}, bus.in_data};

`ifdef IIR_DECIM_ROUND_EN
  assign rnd_c = sum_c + ACC_W'(DECIM / 2);
`else
  assign rnd_c = sum_c;
`endif

  // Average of DATA_W-bit samples always fits back into DATA_W
  assign result_c = DATA_W'(rnd_c >>> LOG2_DECIM);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    push_c  = 1'b0;
    case (state_q)
      ACCUM: if (accept_c && cnt_q == LOG2_DECIM'(DECIM - 2)) state_d = LAST;
      LAST: begin
        if (accept_c) begin
          state_d = ACCUM;
          push_c  = 1'b1;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (accept_c) begin
        if (push_c) begin
          acc_q <= '0;
          cnt_q <= '0;
        end else begin
          acc_q <= sum_c;
          cnt_q <= cnt_q + LOG2_DECIM'(1);
        end
      end
      if (push_c && full && !pop_c) overrun_q <= 1'b1;
    end
  end

  iir_out_fifo #(
    .DEPTH (FIFO_D)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .din   (result_c),
    .dout  (bus.out_data),
    .full  (full),
    .empty (empty)
  );

  assign bus.out_valid = ~empty;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_iir_decimator.sv
// Self-checking bench for iir_decimator (DECIM=4) with a queue-based output scoreboard.
module tb_iir_decimator;
  import iir_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  int   sb_q[$];
  int   m_sum;
  int   m_cnt;
  logic m_ovr;
  bit   mon_en = 1'b0;

  iir_decimator_if bus();

  iir_decimator #(
    .DATA_W (IIR_DATA_W),
    .DECIM  (4),
    .FIFO_D (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: expected results are queued as blocks complete, dropped from the front on a pop
  always @(posedge clk) begin
    int r;
    if (rst) begin
      sb_q.delete();
      m_sum = 0;
      m_cnt = 0;
      m_ovr = 1'b0;
    end else begin
      if (sb_q.size() > 0 && bus.out_ready) void'(sb_q.pop_front());
      if (bus.in_valid && !bus.sleep) begin
        m_sum += int'(bus.in_data);
        m_cnt++;
        if (m_cnt == 4) begin
`ifdef IIR_DECIM_ROUND_EN
          r = (m_sum + 2) >>> 2;
`else
          r = m_sum >>> 2;
`endif
          if (sb_q.size() < 2) sb_q.push_back(r);
          else                 m_ovr = 1'b1;
          m_sum = 0;
          m_cnt = 0;
        end
      end
    end
  end

  // Every cycle, the DUT output must match the scoreboard head
  always @(negedge clk) begin
    logic [7:0] exp8;
    if (mon_en) begin
      total++;
      if (bus.out_valid !== (sb_q.size() != 0)) begin
        bad++;
        $display("FAIL sb_valid t=%0t got=%b exp=%b", $time, bus.out_valid, sb_q.size() != 0);
      end
      if (sb_q.size() != 0) begin
        exp8 = 8'(sb_q[0]);
        total++;
        if (bus.out_data !== exp8) begin
          bad++;
          $display("FAIL sb_data t=%0t got=%0d exp=%0d", $time, bus.out_data, sb_q[0]);
        end
      end
      total++;
      if (bus.overrun !== m_ovr) begin
        bad++;
        $display("FAIL sb_overrun t=%0t got=%b exp=%b", $time, bus.overrun, m_ovr);
      end
    end
  end

  task automatic send(input int v);
    @(negedge clk);
    bus.sleep    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'(v);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.sleep    = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.sleep     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    total++;
    if (bus.out_data !== 8'sd0) begin bad++; $display("FAIL reset_data got=%0d exp=0", bus.out_data); end
    total++;
    if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_average();
    sample_t exp_v;
    exp_v = 25;
    repeat (2) @(negedge clk);
    send(10); send(20); send(30); send(40);
    idle();
    total++;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL avg_valid got=%b exp=1", bus.out_valid); end
    total++;
    if (bus.out_data !== exp_v) begin bad++; $display("FAIL avg_data got=%0d exp=%0d", bus.out_data, exp_v); end
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL avg_one_cycle got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_round();
    sample_t exp_v;
`ifdef IIR_DECIM_ROUND_EN
    exp_v = -1;
`else
    exp_v = -2;
`endif
    repeat (2) @(negedge clk);
    send(-1); send(-1); send(-1); send(-2);
    idle();
    total++;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL round_valid got=%b exp=1", bus.out_valid); end
    total++;
    if (bus.out_data !== exp_v) begin bad++; $display("FAIL round_data got=%0d exp=%0d", bus.out_data, exp_v); end
  endtask

  task automatic test_no_wrap();
    sample_t exp_hi;
    sample_t exp_lo;
    exp_hi = 127;
    exp_lo = -128;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) send(127);
    idle();
    total++;
    if (bus.out_data !== exp_hi) begin bad++; $display("FAIL max_data got=%0d exp=%0d", bus.out_data, exp_hi); end
    for (int i = 0; i < 4; i++) send(-128);
    idle();
    total++;
    if (bus.out_data !== exp_lo) begin bad++; $display("FAIL min_data got=%0d exp=%0d", bus.out_data, exp_lo); end
  endtask

  task automatic test_overrun();
    sample_t exp_a;
    sample_t exp_b;
    exp_a = 1;
    exp_b = 2;
    repeat (2) @(negedge clk);
    bus.out_ready = 1'b0;
    for (int b = 1; b <= 3; b++) begin
      for (int i = 0; i < 4; i++) send(b);
    end
    idle();
    total++;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b exp=1", bus.out_valid); end
    total++;
    if (bus.out_data !== exp_a) begin bad++; $display("FAIL ovr_head got=%0d exp=%0d", bus.out_data, exp_a); end
    total++;
    if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", bus.overrun); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.out_data !== exp_b) begin bad++; $display("FAIL ovr_second got=%0d exp=%0d", bus.out_data, exp_b); end
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ovr_drained got=%b exp=0", bus.out_valid); end
    total++;
    if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", bus.overrun); end
  endtask

  task automatic test_sleep();
    sample_t exp_v;
    exp_v = 8;
    repeat (2) @(negedge clk);
    send(8); send(8);
    repeat (5) begin
      @(negedge clk);
      bus.sleep    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'sd100;
    end
    @(negedge clk);
    bus.sleep    = 1'b1;
    bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL sleep_hold got=%b exp=0", bus.out_valid); end
    send(8); send(8);
    idle();
    total++;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL sleep_valid got=%b exp=1", bus.out_valid); end
    total++;
    if (bus.out_data !== exp_v) begin bad++; $display("FAIL sleep_data got=%0d exp=%0d", bus.out_data, exp_v); end
  endtask

  task automatic test_mid_reset();
    sample_t exp_v;
    exp_v = 4;
    repeat (2) @(negedge clk);
    send(50); send(50); send(50);
    idle();
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL pre_reset_valid got=%b exp=0", bus.out_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (bus.overrun !== 1'b0) begin bad++; $display("FAIL rst_clears_overrun got=%b exp=0", bus.overrun); end
    for (int i = 0; i < 4; i++) send(4);
    idle();
    total++;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL post_reset_valid got=%b exp=1", bus.out_valid); end
    total++;
    if (bus.out_data !== exp_v) begin bad++; $display("FAIL post_reset_data got=%0d exp=%0d", bus.out_data, exp_v); end
    total++;
    if (bus.overrun !== 1'b0) begin bad++; $display("FAIL post_reset_overrun got=%b exp=0", bus.overrun); end
  endtask

  initial begin
    test_reset();
    test_average();
    test_round();
    test_no_wrap();
    test_overrun();
    test_sleep();
    test_mid_reset();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
